// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: access sizes, FSM states, owners.
// Also holds the alignment check used by both arbitration and error reporting.
package mem_arb_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Size 3 is never legal; halves need an even address, words a 4-byte one.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_H && off[0]) ||
           (size == SIZE_W && off != 2'b00) ||
           (size == 2'd3);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/replication and load
// right-alignment with zero or sign extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (st_size)
      SIZE_B: begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        wstrb = 4'b0011 << st_off;
        wdata = {2{st_data[15:0]}};
      end
      SIZE_W: begin
        wstrb = 4'b1111;
        wdata = st_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = ld_raw >> {ld_off, 3'b000};
    case (ld_size)
      SIZE_B:  ld_data = {{24{ld_sext & shifted[7]}}, shifted[7:0]};
      SIZE_H:  ld_data = {{16{ld_sext & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store,
// with a fetch starvation guard and a single outstanding read.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_sext,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t      state_reg, state_next;
  owner_t      owner_reg;
  logic [3:0]  starve_cnt_reg;
  logic [2:0]  lat_cnt_reg;
  logic [1:0]  off_reg, size_reg;
  logic        sext_reg;
  logic [31:0] rdata_reg;

  logic        fetch_wins, d_bad, d_go, rd_start, lat_done;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata, ld_data;

  mem_lane_align u_align (
    .st_size (d_size),
    .st_off  (d_addr[1:0]),
    .st_data (d_wdata),
    .wstrb   (st_wstrb),
    .wdata   (st_wdata),
    .ld_size (size_reg),
    .ld_off  (off_reg),
    .ld_sext (sext_reg),
    .ld_raw  (mem_rdata),
    .ld_data (ld_data)
  );

  assign fetch_wins = if_req && (!d_req || starve_cnt_reg == 4'(STARVE_MAX));
  assign d_bad      = is_misaligned(d_size, d_addr[1:0]);
  assign lat_done   = (lat_cnt_reg == 3'(RD_LAT));

  // Grants are qualified with rst so every output is quiet while reset is held.
  always_comb begin
    state_next = state_reg;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    d_go       = 1'b0;
    rd_start   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rst) begin
          if_gnt = fetch_wins;
          d_gnt  = d_req && !fetch_wins;
        end
        d_go     = d_gnt && !d_bad;
        rd_start = if_gnt || (d_go && !d_we);
        if (rd_start) state_next = RD_WAIT;
      end
      RD_WAIT: if (lat_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign d_err     = d_gnt && d_bad;
  assign mem_en    = if_gnt || d_go;
  assign mem_we    = d_go && d_we;
  assign mem_wstrb = mem_we ? st_wstrb : 4'b0000;
  assign mem_wdata = mem_we ? st_wdata : 32'h0;
  assign mem_addr  = if_gnt ? (if_addr & WORD_MASK) :
                     d_go   ? (d_addr & WORD_MASK)  : '0;

  assign if_rvalid = (state_reg == RESP) && (owner_reg == OWN_IF);
  assign d_rvalid  = (state_reg == RESP) && (owner_reg == OWN_D);
  assign if_rdata  = if_rvalid ? rdata_reg : 32'h0;
  assign d_rdata   = d_rvalid  ? rdata_reg : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_IF;
      starve_cnt_reg <= 4'd0;
      lat_cnt_reg    <= 3'd0;
      off_reg        <= 2'd0;
      size_reg       <= 2'd0;
      sext_reg       <= 1'b0;
      rdata_reg      <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (rd_start) begin
        owner_reg   <= if_gnt ? OWN_IF : OWN_D;
        off_reg     <= d_addr[1:0];
        size_reg    <= d_size;
        sext_reg    <= d_sext;
        lat_cnt_reg <= 3'd1;
      end else if (state_reg == RD_WAIT) begin
        lat_cnt_reg <= lat_cnt_reg + 3'd1;
      end
      // Loads are aligned at capture; fetch words go through untouched.
      if (state_reg == RD_WAIT && lat_done)
        rdata_reg <= (owner_reg == OWN_D) ? ld_data : mem_rdata;
      if (if_gnt || !if_req)
        starve_cnt_reg <= 4'd0;
      else if (d_gnt && starve_cnt_reg != 4'(STARVE_MAX))
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (RD_LAT=1, STARVE_MAX=4): fetch, stores,
// load extension, misalignment, starvation guard and reset mid-read.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, d_sext;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_addr;
  logic [3:0]  mem_wstrb;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sext(d_sext),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sext, input logic [31:0] exp);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_size = size; d_sext = sext; d_addr = addr;
    #2;
    chk({tag, "_gnt"}, 32'(d_gnt), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, addr & ~32'd3);
    tick();
    d_req = 1'b0;
    #2;
    chk({tag, "_wait_rvalid"}, 32'(d_rvalid), 32'd0);
    tick(); #2;
    chk({tag, "_rvalid"}, 32'(d_rvalid), 32'd1);
    chk({tag, "_rdata"}, d_rdata, exp);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    tick(); #2;
    chk({tag, "_rvalid_end"}, 32'(d_rvalid), 32'd0);
    chk({tag, "_rdata_end"}, d_rdata, 32'h0);
    $display("txn load %s addr=%h size=%0d sext=%0d rdata=%h", tag, addr, size, sext, exp);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'd0; d_sext = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
    #12;
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rvalid", 32'(if_rvalid | d_rvalid), 32'd0);
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    $display("txn reset released");

    // Fetch at 0x40 with a store queued behind it during the read.
    tick();
    mem_rdata = 32'h12345678; if_req = 1'b1; if_addr = 32'h40;
    #2;
    chk("f_gnt", 32'(if_gnt), 32'd1);
    chk("f_mem_en", 32'(mem_en), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_wstrb", 32'(mem_wstrb), 32'd0);
    chk("f_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h103; d_wdata = 32'h123456AB;
    #2;
    chk("f_wait_rvalid", 32'(if_rvalid), 32'd0);
    chk("f_wait_d_gnt", 32'(d_gnt), 32'd0);
    tick(); #2;
    chk("f_rvalid", 32'(if_rvalid), 32'd1);
    chk("f_rdata", if_rdata, 32'h12345678);
    chk("f_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("f_resp_d_gnt", 32'(d_gnt), 32'd0);
    $display("txn fetch addr=00000040 rdata=12345678");

    tick(); #2;
    chk("f_rvalid_end", 32'(if_rvalid), 32'd0);
    chk("f_rdata_end", if_rdata, 32'h0);
    chk("sb_gnt", 32'(d_gnt), 32'd1);
    chk("sb_we", 32'(mem_we), 32'd1);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_err", 32'(d_err), 32'd0);
    $display("txn sb addr=00000103 wdata=abababab");

    tick();
    d_size = 2'd1; d_addr = 32'h22; d_wdata = 32'hBEEF1234;
    #2;
    chk("sh_gnt", 32'(d_gnt), 32'd1);
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    chk("sh_addr", mem_addr, 32'h20);
    $display("txn sh addr=00000022 wdata=12341234");
    tick();
    d_size = 2'd2; d_addr = 32'h30; d_wdata = 32'hDEADBEEF;
    #2;
    chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    $display("txn sw addr=00000030 wdata=deadbeef");
    tick();
    d_req = 1'b0;
    #2;
    chk("st_idle_en", 32'(mem_en), 32'd0);
    chk("st_no_rvalid", 32'(d_rvalid), 32'd0);

    mem_rdata = 32'h80017FFF;
    do_load("lh", 32'h202, 2'd1, 1'b1, 32'hFFFF8001);
    do_load("lhu", 32'h202, 2'd1, 1'b0, 32'h00008001);
    do_load("lb", 32'h203, 2'd0, 1'b1, 32'hFFFFFF80);
    do_load("lw", 32'h200, 2'd2, 1'b0, 32'h80017FFF);

    // Misaligned word load, then illegal size on an aligned address.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h102;
    #2;
    chk("mis_gnt", 32'(d_gnt), 32'd1);
    chk("mis_err", 32'(d_err), 32'd1);
    chk("mis_mem_en", 32'(mem_en), 32'd0);
    $display("txn lw misaligned addr=00000102 err");
    tick();
    d_we = 1'b1; d_size = 2'd3; d_addr = 32'h100;
    #2;
    chk("sz3_gnt", 32'(d_gnt), 32'd1);
    chk("sz3_err", 32'(d_err), 32'd1);
    chk("sz3_mem_we", 32'(mem_we), 32'd0);
    $display("txn size3 addr=00000100 err");
    tick();
    d_req = 1'b0;
    #2;
    chk("mis_err_end", 32'(d_err), 32'd0);
    chk("mis_no_rvalid", 32'(d_rvalid), 32'd0);

    // Starvation guard: four data wins, then fetch on the fifth arbitration.
    tick();
    mem_rdata = 32'hCAFEF00D;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h10; d_wdata = 32'h11;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("stv_d_gnt", 32'(d_gnt), 32'd1);
      chk("stv_if_gnt", 32'(if_gnt), 32'd0);
      tick();
    end
    #2;
    chk("stv_fetch_gnt", 32'(if_gnt), 32'd1);
    chk("stv_fetch_d_gnt", 32'(d_gnt), 32'd0);
    chk("stv_fetch_addr", mem_addr, 32'h80);
    $display("txn starvation fetch granted after 4 stores");
    tick(); #2;
    chk("stv_wait_gnt", 32'(d_gnt | if_gnt), 32'd0);
    tick(); #2;
    chk("stv_rvalid", 32'(if_rvalid), 32'd1);
    chk("stv_rdata", if_rdata, 32'hCAFEF00D);
    chk("stv_resp_gnt", 32'(d_gnt | if_gnt), 32'd0);
    tick(); #2;
    chk("stv_cleared_d_gnt", 32'(d_gnt), 32'd1);
    chk("stv_cleared_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    if_req = 1'b0; d_req = 1'b0;

    // Reset while a fetch sits in RD_WAIT.
    tick();
    if_req = 1'b1; if_addr = 32'h44;
    #2;
    chk("rw_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0; d_req = 1'b1;
    #2;
    chk("rw_wait_d_gnt", 32'(d_gnt), 32'd0);
    rst = 1'b1;
    #1;
    chk("rw_rst_rvalid", 32'(if_rvalid), 32'd0);
    chk("rw_rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rw_rst_mem_en", 32'(mem_en), 32'd0);
    tick(); #2;
    chk("rw_rst_hold_rvalid", 32'(if_rvalid), 32'd0);
    chk("rw_rst_hold_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    rst = 1'b0; d_req = 1'b0;
    #2;
    chk("rw_post_rvalid", 32'(if_rvalid), 32'd0);
    tick(); #2;
    chk("rw_post_rvalid2", 32'(if_rvalid), 32'd0);
    $display("txn reset during RD_WAIT, pending fetch dropped");
    tick();
    if_req = 1'b1; if_addr = 32'h48;
    #2;
    chk("rw_new_gnt", 32'(if_gnt), 32'd1);
    chk("rw_new_addr", mem_addr, 32'h48);
    tick();
    if_req = 1'b0;
    tick(); #2;
    chk("rw_new_rvalid", 32'(if_rvalid), 32'd1);
    chk("rw_new_rdata", if_rdata, 32'hCAFEF00D);
    $display("txn fetch addr=00000048 after reset rdata=cafef00d");
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
